// File: rtl/rca_config.sv
// rca_config: shared types and defaults for the RCA load/store queue.
//   lsq_entry_t      - one queued memory operation (addr, data, fn3, load, store)
//   lsq_lock_state_t - LSU lock FSM states
//   row_is_valid()   - a grid row request is real only with exactly one op type set
package rca_config;

    localparam int XLEN              = 32;
    localparam int RCA_GRID_NUM_ROWS = 4;
    localparam int RCA_LSQ_DEPTH     = 8;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
        logic            store;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        LOCK_IDLE   = 2'd0,
        LOCK_LOCKED = 2'd1,
        LOCK_DRAIN  = 2'd2
    } lsq_lock_state_t;

    function automatic logic row_is_valid(input logic req, input logic ld, input logic st);
        return req & (ld ^ st);
    endfunction

endpackage

// File: rtl/rca_lsq_if.sv
// Bundled views of the LSQ connections.
//   rca_lsq_grid_interface : per-row requests from the grid, fifo_full back
//   rca_lsu_interface      : head entry + new_request to the LSU, ready back
interface rca_lsq_grid_interface
    import rca_config::*;
#(
    parameter int GRID_NUM_ROWS = RCA_GRID_NUM_ROWS
);
    logic [GRID_NUM_ROWS-1:0][XLEN-1:0] addr;
    logic [GRID_NUM_ROWS-1:0][XLEN-1:0] data;
    logic [GRID_NUM_ROWS-1:0][2:0]      fn3;
    logic [GRID_NUM_ROWS-1:0]           load;
    logic [GRID_NUM_ROWS-1:0]           store;
    logic [GRID_NUM_ROWS-1:0]           new_request;
    logic                               fifo_full;

    modport lsq  (input addr, data, fn3, load, store, new_request, output fifo_full);
    modport grid (output addr, data, fn3, load, store, new_request, input fifo_full);
endinterface

interface rca_lsu_interface
    import rca_config::*;
;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            rca_lsu_lock;
    logic            ready;

    modport lsq (output rs1, rs2, fn3, load, store, new_request, rca_lsu_lock, input ready);
    modport lsu (input rs1, rs2, fn3, load, store, new_request, rca_lsu_lock, output ready);
endinterface

// File: rtl/rca_lsq_compactor.sv
// rca_lsq_compactor: exclusive prefix count of valid rows.
//   row_valid : per-row valid strobe
//   prefix[i] : number of valid rows with index < i (slot offset from tail)
//   total     : number of valid rows this cycle
module rca_lsq_compactor #(
    parameter int GRID_NUM_ROWS = 4,
    parameter int CW            = $clog2(GRID_NUM_ROWS + 1)
) (
    input  logic [GRID_NUM_ROWS-1:0]         row_valid,
    output logic [GRID_NUM_ROWS-1:0][CW-1:0] prefix,
    output logic [CW-1:0]                    total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(row_valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/rca_lsq.sv
// rca_lsq: multi-push, single-pop load/store queue between the RCA grid and the LSU.
//   clk, rst             : clock, async active-low reset
//   grid_*               : per-row request fields and strobe
//   fifo_full            : fewer than GRID_NUM_ROWS free entries
//   rs1/rs2/fn3/load/store, new_request : head entry to the LSU (zero when empty)
//   lsu_ready            : LSU takes the head entry this cycle
//   rca_lsu_lock         : LSU reserved for RCA traffic
//   rca_flush            : synchronous discard of all entries
module rca_lsq
    import rca_config::*;
#(
    parameter int LSQ_DEPTH     = RCA_LSQ_DEPTH,
    parameter int GRID_NUM_ROWS = RCA_GRID_NUM_ROWS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_addr,
    input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0] grid_data,
    input  logic [GRID_NUM_ROWS-1:0][2:0]      grid_fn3,
    input  logic [GRID_NUM_ROWS-1:0]           grid_load,
    input  logic [GRID_NUM_ROWS-1:0]           grid_store,
    input  logic [GRID_NUM_ROWS-1:0]           grid_new_request,
    output logic                               fifo_full,
    output logic [XLEN-1:0]                    rs1,
    output logic [XLEN-1:0]                    rs2,
    output logic [2:0]                         fn3,
    output logic                               load,
    output logic                               store,
    output logic                               new_request,
    output logic                               rca_lsu_lock,
    input  logic                               lsu_ready,
    input  logic                               rca_flush
);

    localparam int PW   = $clog2(LSQ_DEPTH);
    localparam int CNTW = $clog2(LSQ_DEPTH + 1);
    localparam int CW   = $clog2(GRID_NUM_ROWS + 1);

    logic [GRID_NUM_ROWS-1:0]         row_valid;
    logic [GRID_NUM_ROWS-1:0][CW-1:0] prefix;
    logic [CW-1:0]                    push_total;
    logic [CW-1:0]                    push_cnt;
    logic                             accept;
    logic                             push_any;
    logic                             pop;

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;

    lsq_entry_t      mem [LSQ_DEPTH];
    lsq_entry_t      head_entry;
    lsq_lock_state_t state;
    lsq_lock_state_t state_next;

    always_comb begin
        row_valid = '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++)
            row_valid[i] = row_is_valid(grid_new_request[i], grid_load[i], grid_store[i]);
    end

    rca_lsq_compactor #(
        .GRID_NUM_ROWS (GRID_NUM_ROWS),
        .CW            (CW)
    ) u_compactor (
        .row_valid (row_valid),
        .prefix    (prefix),
        .total     (push_total)
    );

    // Full is judged from the registered count only, so the grid never sees
    // a combinational path from its own requests back to its backpressure.
    assign fifo_full   = (LSQ_DEPTH - int'(count)) < GRID_NUM_ROWS;
    assign accept      = !fifo_full && !rca_flush;
    assign push_cnt    = accept ? push_total : '0;
    assign push_any    = (push_cnt != '0);
    assign new_request = (count != '0);
    assign pop         = new_request && lsu_ready;
    assign count_next  = count + CNTW'(push_cnt) - CNTW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rca_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push_cnt);
            count <= count_next;
        end
    end

    // Entry storage carries no reset: validity lives entirely in count.
    // Rows land at tail + their prefix, so valid rows pack contiguously in row order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            if (accept && row_valid[i])
                mem[tail + PW'(prefix[i])] <= lsq_entry_t'{
                    addr:  grid_addr[i],
                    data:  grid_data[i],
                    fn3:   grid_fn3[i],
                    load:  grid_load[i],
                    store: grid_store[i]
                };
        end
    end

    // A freshly pushed entry is only visible once count is updated, so an
    // empty queue never forwards a same-cycle push to the LSU.
    assign head_entry = new_request ? mem[head] : '0;
    assign rs1        = head_entry.addr;
    assign rs2        = head_entry.data;
    assign fn3        = head_entry.fn3;
    assign load       = head_entry.load;
    assign store      = head_entry.store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOCK_IDLE;
        else      state <= state_next;
    end

    // DRAIN holds the lock one extra cycle after the queue empties so the
    // LSU's last RCA access is not interleaved with core traffic.
    always_comb begin
        state_next = state;
        unique case (state)
            LOCK_IDLE:   if (push_any) state_next = LOCK_LOCKED;
            LOCK_LOCKED: if (!push_any && count_next == '0) state_next = LOCK_DRAIN;
            LOCK_DRAIN:  state_next = push_any ? LOCK_LOCKED : LOCK_IDLE;
            default:     state_next = LOCK_IDLE;
        endcase
        if (rca_flush) state_next = LOCK_IDLE;
    end

    assign rca_lsu_lock = (state != LOCK_IDLE);

    // Requests presented while full are dropped; the grid should never do this.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_full && (|row_valid)))
        else $error("rca_lsq: request dropped while fifo_full");

endmodule

// File: tb/tb_rca_lsq.sv
module tb_rca_lsq;
    import rca_config::*;

    localparam int R = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [R-1:0][XLEN-1:0] grid_addr, grid_data;
    logic [R-1:0][2:0]      grid_fn3;
    logic [R-1:0]           grid_load, grid_store, grid_new_request;
    logic                   fifo_full, load, store, new_request, rca_lsu_lock;
    logic [XLEN-1:0]        rs1, rs2;
    logic [2:0]             fn3;
    logic                   lsu_ready, rca_flush;

    rca_lsq #(.LSQ_DEPTH(D), .GRID_NUM_ROWS(R)) dut (
        .clk(clk), .rst(rst),
        .grid_addr(grid_addr), .grid_data(grid_data), .grid_fn3(grid_fn3),
        .grid_load(grid_load), .grid_store(grid_store), .grid_new_request(grid_new_request),
        .fifo_full(fifo_full), .rs1(rs1), .rs2(rs2), .fn3(fn3), .load(load), .store(store),
        .new_request(new_request), .rca_lsu_lock(rca_lsu_lock),
        .lsu_ready(lsu_ready), .rca_flush(rca_flush)
    );

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            ld;
        logic            st;
    } exp_t;

    typedef struct {
        logic [R-1:0] nr;
        logic [R-1:0] ld;
        logic [R-1:0] st;
        int           exp_push;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every LSU handshake must match the oldest modelled entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && new_request === 1'b1 && lsu_ready === 1'b1) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=0x%0h required=none", rs1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_entry", {rs1, rs2, fn3, load, store}, {e.addr, e.data, e.fn3, e.ld, e.st});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rows();
        grid_new_request = '0;
        grid_load        = '0;
        grid_store       = '0;
        grid_addr        = '0;
        grid_data        = '0;
        grid_fn3         = '0;
    endtask

    task automatic set_row(input int i, input logic nr, input logic ld, input logic st,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [2:0] f);
        grid_new_request[i] = nr;
        grid_load[i]        = ld;
        grid_store[i]       = st;
        grid_addr[i]        = a;
        grid_data[i]        = d;
        grid_fn3[i]         = f;
    endtask

    // Reference: a row enqueues only with its strobe and exactly one op bit.
    task automatic model_rows();
        for (int i = 0; i < R; i++) begin
            if (grid_new_request[i] && (grid_load[i] != grid_store[i])) begin
                exp_t e;
                e.addr = grid_addr[i];
                e.data = grid_data[i];
                e.fn3  = grid_fn3[i];
                e.ld   = grid_load[i];
                e.st   = grid_store[i];
                sb.push_back(e);
            end
        end
    endtask

    task automatic set_pat(input logic [R-1:0] nr, input logic [R-1:0] ld, input logic [R-1:0] st,
                           input logic [XLEN-1:0] base);
        for (int i = 0; i < R; i++)
            set_row(i, nr[i], ld[i], st[i], base + XLEN'(i * 16),
                    (base ^ 32'hDEAD_0000) + XLEN'(i), 3'(i + 1));
    endtask

    task automatic push_pat(input logic [R-1:0] nr, input logic [R-1:0] ld, input logic [R-1:0] st,
                            input logic [XLEN-1:0] base);
        set_pat(nr, ld, st, base);
        model_rows();
        tick();
        clear_rows();
    endtask

    task automatic drain(output int n);
        int k;
        pops      = 0;
        lsu_ready = 1'b1;
        k         = 0;
        while (new_request && k < 40) begin
            tick();
            k++;
        end
        lsu_ready = 1'b0;
        if (new_request) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=<40", k);
        end
        n = pops;
    endtask

    initial begin
        int n;
        vecs[0] = '{nr: 4'b1111, ld: 4'b1111, st: 4'b0000, exp_push: 4};
        vecs[1] = '{nr: 4'b0101, ld: 4'b0001, st: 4'b0100, exp_push: 2};
        vecs[2] = '{nr: 4'b1111, ld: 4'b1010, st: 4'b1010, exp_push: 0};
        vecs[3] = '{nr: 4'b0000, ld: 4'b1111, st: 4'b0000, exp_push: 0};
        vecs[4] = '{nr: 4'b1001, ld: 4'b1000, st: 4'b0001, exp_push: 2};
        vecs[5] = '{nr: 4'b1110, ld: 4'b0110, st: 4'b1000, exp_push: 3};

        rst       = 1'b0;
        lsu_ready = 1'b0;
        rca_flush = 1'b0;
        clear_rows();
        #12;
        chk("reset_new_request", new_request, 0);
        chk("reset_lock", rca_lsu_lock, 0);
        chk("reset_full", fifo_full, 0);
        chk("reset_rs1", rs1, 0);
        #5 rst = 1'b1;
        tick();

        // Table: validity filtering and compaction on an empty queue.
        for (int v = 0; v < 6; v++) begin
            push_pat(vecs[v].nr, vecs[v].ld, vecs[v].st, 32'h1000 * XLEN'(v + 1));
            chk($sformatf("vec%0d_valid", v), new_request, 1'(vecs[v].exp_push != 0));
            drain(n);
            chk($sformatf("vec%0d_count", v), n, vecs[v].exp_push);
            tick();
            chk($sformatf("vec%0d_lock_idle", v), rca_lsu_lock, 0);
        end

        // Rows 0,2,3 in one cycle stream out back to back; lock falls after DRAIN.
        lsu_ready = 1'b1;
        set_row(0, 1, 1, 0, 32'h100, 32'hA0, 3'b010);
        set_row(2, 1, 1, 0, 32'h200, 32'hA2, 3'b100);
        set_row(3, 1, 1, 0, 32'h300, 32'hA3, 3'b101);
        model_rows();
        chk("no_bypass", new_request, 0);
        tick();
        clear_rows();
        chk("seq_rs1_0", {new_request, rs1}, {1'b1, 32'h100});
        tick();
        chk("seq_rs1_1", {new_request, rs1}, {1'b1, 32'h200});
        tick();
        chk("seq_rs1_2", {new_request, rs1}, {1'b1, 32'h300});
        tick();
        chk("seq_drain", {new_request, rca_lsu_lock}, 2'b01);
        tick();
        chk("seq_lock_drop", rca_lsu_lock, 0);
        lsu_ready = 1'b0;

        // Backpressure threshold: 5 entries leaves 3 free.
        push_pat(4'b1111, 4'b1111, 4'b0000, 32'h2000);
        chk("full_at_4", fifo_full, 0);
        push_pat(4'b0001, 4'b0001, 4'b0000, 32'h3000);
        chk("full_at_5", fifo_full, 1);
        lsu_ready = 1'b1;
        tick();
        lsu_ready = 1'b0;
        chk("full_after_pop", fifo_full, 0);
        drain(n);
        chk("full_rest", n, 4);

        // Pop and 2-row push together at count=1.
        push_pat(4'b0001, 4'b0000, 4'b0001, 32'h4000);
        set_pat(4'b0011, 4'b0000, 4'b0011, 32'h5000);
        model_rows();
        lsu_ready = 1'b1;
        tick();
        clear_rows();
        lsu_ready = 1'b0;
        drain(n);
        chk("push_pop_count", n, 2);

        // Wrap-around: fill to 7, drain, then fill to 8 across the index boundary.
        push_pat(4'b1111, 4'b1111, 4'b0000, 32'h6000);
        push_pat(4'b0111, 4'b0000, 4'b0111, 32'h7000);
        chk("wrap_full7", fifo_full, 1);
        drain(n);
        chk("wrap_count7", n, 7);
        push_pat(4'b1111, 4'b0101, 4'b1010, 32'h8000);
        push_pat(4'b1111, 4'b1010, 4'b0101, 32'h9000);
        chk("wrap_full8", fifo_full, 1);
        drain(n);
        chk("wrap_count8", n, 8);

        // Asynchronous reset with 6 entries queued.
        push_pat(4'b1111, 4'b1111, 4'b0000, 32'hA000);
        push_pat(4'b0011, 4'b0011, 4'b0000, 32'hB000);
        chk("pre_reset", {new_request, rca_lsu_lock, fifo_full}, 3'b111);
        #2 rst = 1'b0;
        #1;
        chk("rst_async", {new_request, rca_lsu_lock, fifo_full}, 3'b000);
        sb.delete();
        #3 rst = 1'b1;
        tick();
        push_pat(4'b0100, 4'b0100, 4'b0000, 32'hC000);
        drain(n);
        chk("post_reset_count", n, 1);

        // Flush mid-stream discards entries and a same-cycle push.
        push_pat(4'b0111, 4'b0111, 4'b0000, 32'hD000);
        sb.delete();
        set_pat(4'b0011, 4'b0011, 4'b0000, 32'hE000);
        rca_flush = 1'b1;
        tick();
        rca_flush = 1'b0;
        clear_rows();
        chk("flush_empty", {new_request, rca_lsu_lock}, 2'b00);
        push_pat(4'b1000, 4'b0000, 4'b1000, 32'hF000);
        drain(n);
        chk("post_flush_count", n, 1);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_lsq.md
RCA_LSQ -- requirements
Module: rca_lsq

Interface
REQ-001 SHALL have parameter LSQ_DEPTH, default 8, meaning queue entries; power of two, >= GRID_NUM_ROWS.
REQ-002 SHALL have parameter GRID_NUM_ROWS, default rca_config value, meaning grid rows able to request per cycle.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 grid_addr[GRID_NUM_ROWS]  in  XLEN  effective address per row, offset already applied.
REQ-007 grid_data[GRID_NUM_ROWS]  in  XLEN  store data per row.
REQ-008 grid_fn3[GRID_NUM_ROWS]  in  3  RISC-V width/sign code per row.
REQ-009 grid_load[GRID_NUM_ROWS], grid_store[GRID_NUM_ROWS]  in  1 each  operation type per row.
REQ-010 grid_new_request[GRID_NUM_ROWS]  in  1  row request strobe.
REQ-011 fifo_full  out  1  grid backpressure: fewer than GRID_NUM_ROWS free entries.
REQ-012 rs1, rs2  out  XLEN  head-entry address and data to LSU.
REQ-013 fn3  out  3; load, store  out  1 each  head-entry fields.
REQ-014 new_request  out  1  head entry valid.
REQ-015 rca_lsu_lock  out  1  LSU reserved for RCA traffic.
REQ-016 lsu_ready  in  1  LSU accepts presented entry this cycle.
REQ-017 rca_flush  in  1  synchronous queue discard.
REQ-018 Ports SHALL map onto rca_lsq_grid_interface.lsq and rca_lsu_interface.lsq; new_request SHALL be added to the lsq/lsu modports.

Function
REQ-019 A row request SHALL be valid when grid_new_request=1 and exactly one of load/store=1; others SHALL be ignored.
REQ-020 All valid rows in one cycle SHALL enqueue in the same cycle, compacted in ascending row index at tail+prefix-count.
REQ-021 Dequeue SHALL occur in the cycle new_request=1 and lsu_ready=1; order SHALL be strict FIFO.
REQ-022 Occupancy SHALL update as count + pushes - pop; simultaneous push and pop SHALL be supported, including on an empty queue (entry appears next cycle, never bypassed).
REQ-023 Pointers SHALL be log2(LSQ_DEPTH) bits and wrap modulo LSQ_DEPTH.
REQ-024 fifo_full SHALL be combinational from registered count: (LSQ_DEPTH - count) < GRID_NUM_ROWS.
REQ-025 Requests arriving while fifo_full=1 SHALL be dropped and SHALL fire a simulation assertion.
REQ-026 new_request SHALL be (count != 0); rs1/rs2/fn3/load/store SHALL come from head registers, zero when empty.
REQ-027 Lock FSM: IDLE->LOCKED when any valid request enqueues; LOCKED->DRAIN when count hits 0 with no push; DRAIN->IDLE after 1 cycle; DRAIN->LOCKED on push.
REQ-028 rca_lsu_lock SHALL be 1 in LOCKED and DRAIN, 0 in IDLE.
REQ-029 rca_flush=1 SHALL zero count and pointers, enter IDLE next cycle, and ignore same-cycle pushes.

Reset
REQ-030 Asserting rst SHALL immediately clear count, pointers, head fields; new_request=0, rca_lsu_lock=0, fifo_full=0, FSM=IDLE.
REQ-031 Reset mid-operation SHALL discard all entries; entry storage RAM need not be cleared.

Structure
REQ-032 lsq_entry_t struct (addr, data, fn3, load, store) and lsq_lock_state_t enum SHALL be in rca_config.
REQ-033 Sub-module rca_lsq_compactor SHALL produce per-row prefix counts and push total.

Verification (GRID_NUM_ROWS=4, LSQ_DEPTH=8)
REQ-034 Rows 0,2,3 load addr 0x100,0x200,0x300 same cycle, lsu_ready=1 -> LSU sees 0x100,0x200,0x300 on consecutive cycles, lock drops 1 cycle after last.
REQ-035 Push 5 entries, lsu_ready=0 -> fifo_full=1 (free=3); one pop -> fifo_full=0.
REQ-036 Fill to 7, drain and refill past index 7 -> wrap-around preserves order and data.
REQ-037 Pop and 2-row push same cycle at count=1 -> count=2 next cycle, order intact.
REQ-038 rst low with count=6 -> new_request=0, lock=0, fifo_full=0 immediately; rca_flush mid-stream -> empty next cycle.
REQ-039 Row with load=store=1 or neither -> not enqueued, count unchanged.
